// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - 256x32 processor data memory with host byte load/dump port
// Sequences IDLE/LOAD/RUN/DUMP and gates the processor through cpu_en.
module data_memory_responder #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] DONE_ADDR = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WR,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    input  logic [ADDR_W-1:0] host_len,
    input  logic              host_start_load,
    input  logic              host_start_run,
    input  logic              host_start_dump,
    input  logic              host_in_valid,
    input  logic [7:0]        host_in_data,
    output logic              host_in_ready,
    output logic              host_out_valid,
    output logic [7:0]        host_out_data,
    input  logic              host_out_ready,
    output logic              cpu_en,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [23:0]       pack_q, pack_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              out_valid_q, out_valid_d;
    logic              fetch_q, fetch_d;
    logic              done_q, done_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              last_word;

    assign readData       = mem[address];
    assign host_in_ready  = (state_q == S_LOAD);
    assign host_out_valid = out_valid_q;
    assign host_out_data  = shreg_q[7:0];
    assign cpu_en         = (state_q == S_RUN);
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign last_word      = ((word_cnt_q + CNT_W'(1)) == len_q);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        byte_cnt_d  = byte_cnt_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        pack_d      = pack_q;
        shreg_d     = shreg_q;
        out_valid_d = out_valid_q;
        fetch_d     = fetch_q;
        done_d      = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = {host_in_data, pack_q};

        case (state_q)
            S_IDLE: begin
                if (host_start_load || host_start_run || host_start_dump) begin
                    len_d      = (host_len == '0) ? DEPTH_C : {1'b0, host_len};
                    ptr_d      = '0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    if (host_start_load) begin
                        state_d = S_LOAD;
                    end else if (host_start_run) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DUMP;
                        fetch_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (host_in_valid) begin
                    // First three bytes shift in from the top; the fourth completes the word directly.
                    if (byte_cnt_q == 2'd3) begin
                        mem_we     = 1'b1;
                        byte_cnt_d = '0;
                        ptr_d      = ptr_q + ADDR_W'(1);
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        if (last_word) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        pack_d     = {host_in_data, pack_q[23:8]};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

            S_RUN: begin
                if (WR) begin
                    mem_we    = 1'b1;
                    mem_waddr = address;
                    mem_wdata = writeData;
                    if (address == DONE_ADDR) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_DUMP: begin
                if (fetch_q) begin
                    shreg_d     = mem[ptr_q];
                    out_valid_d = 1'b1;
                    fetch_d     = 1'b0;
                end else if (out_valid_q && host_out_ready) begin
                    if (byte_cnt_q == 2'd3) begin
                        out_valid_d = 1'b0;
                        byte_cnt_d  = '0;
                        ptr_d       = ptr_q + ADDR_W'(1);
                        word_cnt_d  = word_cnt_q + CNT_W'(1);
                        if (last_word) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            fetch_d = 1'b1;
                        end
                    end else begin
                        shreg_d    = shreg_q >> 8;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            byte_cnt_q  <= '0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            pack_q      <= '0;
            shreg_q     <= '0;
            out_valid_q <= 1'b0;
            fetch_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            pack_q      <= pack_d;
            shreg_q     <= shreg_d;
            out_valid_q <= out_valid_d;
            fetch_q     <= fetch_d;
            done_q      <= done_d;
        end
    end

    // Storage keeps its contents across reset; write enable is already gated by state.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - self-checking bench for data_memory_responder
`timescale 1ns/1ps
module tb_data_memory_responder;

    typedef logic [7:0] byte_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        WR;
    logic [7:0]  address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic [7:0]  host_len;
    logic        host_start_load, host_start_run, host_start_dump;
    logic        host_in_valid;
    logic [7:0]  host_in_data;
    logic        host_in_ready;
    logic        host_out_valid;
    logic [7:0]  host_out_data;
    logic        host_out_ready;
    logic        cpu_en, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [256];

    always #5 clk = ~clk;

    data_memory_responder dut (
        .clk(clk), .rst(rst), .WR(WR), .address(address), .writeData(writeData),
        .readData(readData), .host_len(host_len), .host_start_load(host_start_load),
        .host_start_run(host_start_run), .host_start_dump(host_start_dump),
        .host_in_valid(host_in_valid), .host_in_data(host_in_data), .host_in_ready(host_in_ready),
        .host_out_valid(host_out_valid), .host_out_data(host_out_data),
        .host_out_ready(host_out_ready), .cpu_en(cpu_en), .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_load(input byte_t b[$], input int words);
        for (int w = 0; w < words; w++) begin
            model_mem[w] = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
        end
    endfunction

    function automatic byte_t model_dump_byte(input int i);
        logic [31:0] w;
        w = model_mem[i / 4] >> (8 * (i % 4));
        return w[7:0];
    endfunction

    task automatic do_load(input int len_cfg, input byte_t b[$], input bit rand_valid, input bit also_dump,
                           output int n_acc, output int n_done, output bit entered, output bit end_ok,
                           output bit tmo);
        int idx = 0;
        int cyc = 0;
        bit acc;
        n_acc = 0; n_done = 0; tmo = 0;
        host_len = 8'(len_cfg);
        host_start_load = 1'b1;
        host_start_dump = also_dump;
        tick();
        host_start_load = 1'b0;
        host_start_dump = 1'b0;
        entered = (host_in_ready === 1'b1) && (host_out_valid === 1'b0) && (cpu_en === 1'b0);
        host_in_data  = b[0];
        host_in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        while (idx < b.size()) begin
            if (cyc > 20000) begin
                tmo = 1'b1;
                break;
            end
            acc = host_in_valid && host_in_ready;
            tick();
            cyc++;
            if (done === 1'b1) n_done++;
            if (acc) begin
                idx++;
                n_acc++;
            end
            if (idx < b.size()) begin
                host_in_data  = b[idx];
                host_in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                host_in_valid = 1'b0;
            end
        end
        end_ok = (done === 1'b1) && (busy === 1'b0) && (host_in_ready === 1'b0);
        host_in_valid = 1'b1;
        tick();
        if (done === 1'b1) n_done++;
        if (host_in_ready !== 1'b0) n_acc++;
        host_in_valid = 1'b0;
    endtask

    task automatic do_dump(input int len_cfg, input bit rand_ready, output byte_t got[$],
                           output int n_done, output int n_unstable, output int n_gap,
                           output int first_lat, output bit end_ok, output bit tmo);
        int total;
        int cyc = 0;
        bit rdy, hold, gap_next;
        byte_t hold_data;
        got.delete();
        n_done = 0; n_unstable = 0; n_gap = 0; first_lat = -1; tmo = 0;
        hold = 0; gap_next = 0; hold_data = 8'h00;
        total = ((len_cfg == 0) ? 256 : len_cfg) * 4;
        host_len = 8'(len_cfg);
        host_start_dump = 1'b1;
        tick();
        host_start_dump = 1'b0;
        while (got.size() < total) begin
            if (cyc > 20000) begin
                tmo = 1'b1;
                break;
            end
            if (hold && (host_out_valid !== 1'b1 || host_out_data !== hold_data)) n_unstable++;
            if (gap_next && host_out_valid !== 1'b0) n_gap++;
            if (host_out_valid === 1'b1 && first_lat < 0) first_lat = cyc + 1;
            rdy = rand_ready ? ($urandom_range(0, 2) != 0) : (cyc % 2 == 0);
            host_out_ready = rdy;
            gap_next = 0;
            if (host_out_valid === 1'b1 && rdy) begin
                got.push_back(host_out_data);
                gap_next = (got.size() % 4 == 0) && (got.size() < total);
            end
            hold = (host_out_valid === 1'b1) && !rdy;
            hold_data = host_out_data;
            tick();
            cyc++;
            if (done === 1'b1) n_done++;
        end
        end_ok = (done === 1'b1) && (busy === 1'b0) && (host_out_valid === 1'b0);
        host_out_ready = 1'b1;
        repeat (3) begin
            tick();
            if (done === 1'b1) n_done++;
            if (host_out_valid !== 1'b0) n_unstable++;
        end
        host_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; WR = 1'b0; address = 8'h00; writeData = 32'h0; host_len = 8'h00;
        host_start_load = 1'b0; host_start_run = 1'b0; host_start_dump = 1'b0;
        host_in_valid = 1'b0; host_in_data = 8'h00; host_out_ready = 1'b0;
        repeat (3) tick();
        n_cmp++; if (host_in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", host_in_ready); end
        n_cmp++; if (host_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", host_out_valid); end
        n_cmp++; if (host_out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h expected 00", host_out_data); end
        n_cmp++; if ({cpu_en, busy, done} !== 3'b000) begin n_bad++; $display("FAIL reset_en_busy_done: got %b expected 000", {cpu_en, busy, done}); end
        rst = 1'b1;
        repeat (2) tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_load_basic();
        byte_t b[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        int n_acc, n_done;
        bit entered, end_ok, tmo;
        do_load(2, b, 1'b0, 1'b0, n_acc, n_done, entered, end_ok, tmo);
        model_load(b, 2);
        n_cmp++; if (tmo) begin n_bad++; $display("FAIL load_basic_timeout: got timeout expected completion"); end
        n_cmp++; if (n_acc != 8) begin n_bad++; $display("FAIL load_basic_accepts: got %0d expected 8", n_acc); end
        n_cmp++; if (n_done != 1 || !end_ok) begin n_bad++; $display("FAIL load_basic_done: got pulses=%0d end_ok=%b expected 1/1", n_done, end_ok); end
        address = 8'h00; #1;
        n_cmp++; if (readData !== 32'h44332211) begin n_bad++; $display("FAIL load_basic_mem0: got %h expected 44332211", readData); end
        address = 8'h01; #1;
        n_cmp++; if (readData !== 32'h88776655) begin n_bad++; $display("FAIL load_basic_mem1: got %h expected 88776655", readData); end
    endtask

    task automatic test_dump_basic();
        byte_t got[$];
        int n_done, n_unst, n_gap, lat;
        bit end_ok, tmo;
        do_dump(2, 1'b0, got, n_done, n_unst, n_gap, lat, end_ok, tmo);
        n_cmp++; if (tmo || got.size() != 8) begin n_bad++; $display("FAIL dump_basic_count: got %0d bytes (tmo=%b) expected 8", got.size(), tmo); end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== 8'(8'h11 * (i + 1))) begin n_bad++; $display("FAIL dump_basic_byte%0d: got %h expected %h", i, got[i], 8'(8'h11 * (i + 1))); end
        end
        n_cmp++; if (n_unst != 0) begin n_bad++; $display("FAIL dump_basic_stable: got %0d violations expected 0", n_unst); end
        n_cmp++; if (n_gap != 0) begin n_bad++; $display("FAIL dump_basic_gap: got %0d missing gaps expected 0", n_gap); end
        n_cmp++; if (lat < 2) begin n_bad++; $display("FAIL dump_basic_latency: got %0d expected >=2", lat); end
        n_cmp++; if (n_done != 1 || !end_ok) begin n_bad++; $display("FAIL dump_basic_done: got pulses=%0d end_ok=%b expected 1/1", n_done, end_ok); end
    endtask

    task automatic test_run();
        logic [31:0] d;
        logic [7:0]  a;
        host_start_run = 1'b1;
        tick();
        host_start_run = 1'b0;
        n_cmp++; if (cpu_en !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL run_enter: got cpu_en=%b busy=%b expected 1/1", cpu_en, busy); end
        WR = 1'b1; address = 8'h10; writeData = 32'hDEADBEEF;
        tick();
        WR = 1'b0;
        model_mem[8'h10] = 32'hDEADBEEF;
        n_cmp++; if (readData !== 32'hDEADBEEF) begin n_bad++; $display("FAIL run_wr10: got %h expected deadbeef", readData); end
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom_range(0, 254));
            d = $urandom;
            WR = 1'b1; address = a; writeData = d;
            tick();
            WR = 1'b0;
            model_mem[a] = d;
            n_cmp++; if (readData !== d || cpu_en !== 1'b1) begin n_bad++; $display("FAIL run_rand_wr%0d: got %h en=%b expected %h en=1", i, readData, cpu_en, d); end
        end
        WR = 1'b1; address = 8'h20; writeData = 32'hA5A50020;
        tick();
        model_mem[8'h20] = 32'hA5A50020;
        d = $urandom;
        address = 8'hFF; writeData = d;
        tick();
        WR = 1'b0;
        model_mem[8'hFF] = d;
        n_cmp++; if (cpu_en !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL run_done: got en=%b done=%b busy=%b expected 0/1/0", cpu_en, done, busy); end
        n_cmp++; if (readData !== d) begin n_bad++; $display("FAIL run_memff: got %h expected %h", readData, d); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL run_done_pulse: got %b expected 0", done); end
        address = 8'h10; #1;
        n_cmp++; if (readData !== model_mem[8'h10]) begin n_bad++; $display("FAIL run_mem10_after: got %h expected %h", readData, model_mem[8'h10]); end
    endtask

    task automatic test_wr_ignored();
        byte_t b[$];
        byte_t got[$];
        int n_acc, n_done, n_unst, n_gap, lat;
        bit entered, end_ok, tmo;
        for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
        address = 8'h20; writeData = 32'h12345678; WR = 1'b1;
        tick();
        WR = 1'b0;
        n_cmp++; if (readData !== model_mem[8'h20]) begin n_bad++; $display("FAIL wr_idle_ignored: got %h expected %h", readData, model_mem[8'h20]); end
        WR = 1'b1; writeData = 32'h87654321;
        do_load(1, b, 1'b0, 1'b0, n_acc, n_done, entered, end_ok, tmo);
        WR = 1'b0;
        model_load(b, 1);
        #1;
        n_cmp++; if (readData !== model_mem[8'h20]) begin n_bad++; $display("FAIL wr_load_ignored: got %h expected %h", readData, model_mem[8'h20]); end
        address = 8'h00; #1;
        n_cmp++; if (readData !== model_mem[0] || tmo) begin n_bad++; $display("FAIL wr_load_word0: got %h expected %h", readData, model_mem[0]); end
        address = 8'h00; WR = 1'b1; writeData = 32'h0BADF00D;
        do_dump(1, 1'b1, got, n_done, n_unst, n_gap, lat, end_ok, tmo);
        WR = 1'b0;
        #1;
        n_cmp++; if (readData !== model_mem[0]) begin n_bad++; $display("FAIL wr_dump_ignored: got %h expected %h", readData, model_mem[0]); end
    endtask

    task automatic test_reset_mid_load();
        byte_t b[$];
        byte_t c[$];
        int idx = 0;
        int cyc = 0;
        bit acc;
        int n_acc, n_done;
        bit entered, end_ok, tmo;
        for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) c.push_back(8'($urandom));
        host_len = 8'd2;
        host_start_load = 1'b1;
        tick();
        host_start_load = 1'b0;
        host_in_valid = 1'b1; host_in_data = b[0];
        while (idx < 6 && cyc < 50) begin
            acc = host_in_valid && host_in_ready;
            tick();
            cyc++;
            if (acc) idx++;
            host_in_data = b[idx];
        end
        n_cmp++; if (idx != 6) begin n_bad++; $display("FAIL midrst_accepts: got %0d expected 6", idx); end
        model_mem[0] = {b[3], b[2], b[1], b[0]};
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({host_in_ready, host_out_valid, cpu_en, busy, done} !== 5'b0 || host_out_data !== 8'h00) begin
            n_bad++; $display("FAIL midrst_outputs: got rdy=%b ov=%b en=%b busy=%b done=%b od=%h expected all 0",
                              host_in_ready, host_out_valid, cpu_en, busy, done, host_out_data);
        end
        host_in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        address = 8'h01; #1;
        n_cmp++; if (readData !== model_mem[1]) begin n_bad++; $display("FAIL midrst_mem1: got %h expected %h", readData, model_mem[1]); end
        do_load(1, c, 1'b1, 1'b0, n_acc, n_done, entered, end_ok, tmo);
        model_load(c, 1);
        address = 8'h00; #1;
        n_cmp++; if (readData !== model_mem[0] || tmo) begin n_bad++; $display("FAIL midrst_reload0: got %h expected %h", readData, model_mem[0]); end
        address = 8'h01; #1;
        n_cmp++; if (readData !== model_mem[1]) begin n_bad++; $display("FAIL midrst_reload1: got %h expected %h", readData, model_mem[1]); end
    endtask

    task automatic test_full_len_priority();
        byte_t b[$];
        byte_t got[$];
        int n_acc, n_done, n_unst, n_gap, lat, bad_words, bad_bytes;
        bit entered, end_ok, tmo;
        for (int i = 0; i < 1024; i++) b.push_back(8'($urandom));
        do_load(0, b, 1'b1, 1'b1, n_acc, n_done, entered, end_ok, tmo);
        model_load(b, 256);
        n_cmp++; if (!entered) begin n_bad++; $display("FAIL prio_load_over_dump: got entered=%b expected 1", entered); end
        n_cmp++; if (tmo || n_acc != 1024) begin n_bad++; $display("FAIL full_load_accepts: got %0d expected 1024", n_acc); end
        n_cmp++; if (n_done != 1 || !end_ok) begin n_bad++; $display("FAIL full_load_done: got pulses=%0d end_ok=%b expected 1/1", n_done, end_ok); end
        bad_words = 0;
        for (int w = 0; w < 256; w++) begin
            address = 8'(w); #1;
            if (readData !== model_mem[w]) bad_words++;
        end
        n_cmp++; if (bad_words != 0) begin n_bad++; $display("FAIL full_load_words: got %0d wrong words expected 0", bad_words); end
        do_dump(0, 1'b1, got, n_done, n_unst, n_gap, lat, end_ok, tmo);
        bad_bytes = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] !== model_dump_byte(i)) bad_bytes++;
        n_cmp++; if (tmo || got.size() != 1024 || bad_bytes != 0) begin n_bad++; $display("FAIL full_dump: got %0d bytes %0d wrong expected 1024/0", got.size(), bad_bytes); end
        n_cmp++; if (n_unst != 0 || n_gap != 0 || n_done != 1 || !end_ok) begin
            n_bad++; $display("FAIL full_dump_proto: got unstable=%0d gap=%0d done=%0d end_ok=%b expected 0/0/1/1", n_unst, n_gap, n_done, end_ok);
        end
    endtask

    task automatic test_random_roundtrip();
        for (int it = 0; it < 4; it++) begin
            byte_t b[$];
            byte_t got[$];
            int len, n_acc, n_done, n_unst, n_gap, lat, bad_bytes;
            bit entered, end_ok, tmo;
            len = $urandom_range(1, 12);
            for (int i = 0; i < 4 * len; i++) b.push_back(8'($urandom));
            do_load(len, b, 1'b1, 1'b0, n_acc, n_done, entered, end_ok, tmo);
            model_load(b, len);
            n_cmp++; if (tmo || n_acc != 4 * len || n_done != 1 || !end_ok) begin
                n_bad++; $display("FAIL rt%0d_load: got acc=%0d done=%0d end_ok=%b expected %0d/1/1", it, n_acc, n_done, end_ok, 4 * len);
            end
            do_dump(len, 1'b1, got, n_done, n_unst, n_gap, lat, end_ok, tmo);
            bad_bytes = 0;
            for (int i = 0; i < got.size(); i++) if (got[i] !== model_dump_byte(i)) bad_bytes++;
            n_cmp++; if (tmo || got.size() != 4 * len || bad_bytes != 0 || n_unst != 0 || n_gap != 0 || n_done != 1) begin
                n_bad++; $display("FAIL rt%0d_dump: got %0d bytes %0d wrong unstable=%0d gap=%0d done=%0d expected %0d/0/0/0/1",
                                  it, got.size(), bad_bytes, n_unst, n_gap, n_done, 4 * len);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_basic();
        test_dump_basic();
        test_run();
        test_wr_ignored();
        test_reset_mid_load();
        test_full_len_priority();
        test_random_roundtrip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Data-memory responder on the processor's memory interface (WR/address/writeData in, readData out). 256 x 32 word store.
- Also owns a byte-wide host port that loads the encrypted image before a run and streams the decrypted result out after it.
- Sequences IDLE/LOAD/RUN/DUMP phases and gates the processor through cpu_en. The processor signals completion by writing DONE_ADDR.

Parameters:
- ADDR_W, 8, processor word-address width.
- DATA_W, 32, word width; fixed at 4 bytes for the host packer.
- DEPTH, 256, number of words; equals 2**ADDR_W.
- DONE_ADDR, 8'hFF, processor write address that ends RUN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- WR  input  1  processor write strobe.
- address  input  ADDR_W  processor word address.
- writeData  input  DATA_W  processor write data.
- readData  output  DATA_W  mem[address], combinational.
- host_len  input  ADDR_W  word count for LOAD/DUMP, latched at start; 0 means DEPTH.
- host_start_load  input  1  single-cycle request to start LOAD.
- host_start_run  input  1  single-cycle request to start RUN.
- host_start_dump  input  1  single-cycle request to start DUMP.
- host_in_valid  input  1  load byte valid.
- host_in_data  input  8  load byte.
- host_in_ready  output  1  responder accepts a load byte.
- host_out_valid  output  1  dump byte valid.
- host_out_data  output  8  dump byte.
- host_out_ready  input  1  host accepts a dump byte.
- cpu_en  output  1  processor run enable.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at the end of any phase.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous, active-low.
- On reset (rst=0):
  - state=IDLE; word pointer, byte counter and length register cleared.
  - host_in_ready=0, host_out_valid=0, host_out_data=0, cpu_en=0, busy=0, done=0.
  - Memory contents are not cleared.
  - Reset mid-phase abandons the phase. A partially packed LOAD word is discarded and never written.
- readData = mem[address] combinational in every state (single-cycle processor). Write-then-read of the same address shows the new data on the cycle after the write edge.
- IDLE:
  - Start pulses are decoded here only; they are ignored in every other state.
  - Simultaneous starts: priority LOAD > RUN > DUMP.
  - Any start latches host_len (0 -> DEPTH) and clears ptr and byte_cnt.
- LOAD:
  - host_in_ready=1 from the cycle after entry.
  - A byte is accepted when host_in_valid & host_in_ready.
  - Bytes pack little-endian: the first byte goes to [7:0], the fourth to [31:24].
  - On the 4th accepted byte, the assembled word is written to mem[ptr] on that same edge, ptr increments (ptr wraps 255 -> 0), and byte_cnt returns to 0.
  - After the last word: host_in_ready=0, state -> IDLE, done=1 for one cycle.
  - Processor WR is ignored.
- RUN:
  - cpu_en=1.
  - WR=1 writes writeData to mem[address] on the rising edge.
  - WR=1 with address==DONE_ADDR also performs the write. Next cycle: state=IDLE, cpu_en=0, done=1 for one cycle.
  - The length register is unused. RUN has no timeout.
- DUMP:
  - Reads mem[ptr] through a 1-cycle registered fetch into a 32-bit shift register.
  - Emits bytes LSB first.
  - host_out_valid asserts at the earliest 2 cycles after entry.
  - Once valid is asserted, host_out_data and host_out_valid hold stable until host_out_ready.
  - After each word's 4th accepted byte, the next word is fetched. There is a one-cycle gap with valid low between words.
  - After the last accepted byte: host_out_valid=0, state -> IDLE, done=1 for one cycle.
  - Processor WR is ignored.
- cpu_en=0 in all states except RUN. WR outside RUN never modifies memory.
- ptr arithmetic is modulo DEPTH. A length of DEPTH covers addresses 0..255 exactly once.

Test Plan:
- LOAD, host_len=2, bytes 11 22 33 44 55 66 77 88 with host_in_valid held high -> mem[0]=32'h44332211, mem[1]=32'h88776655; done pulses once on the cycle after the 8th accept; busy=0 afterwards.
- DUMP, host_len=2 after the previous load, host_out_ready toggling 1,0,1,0 -> bytes 11..88 in order; data stable while ready=0; exactly 8 handshakes; then done.
- RUN: WR to 8'h10 with 32'hDEADBEEF -> readData=DEADBEEF at address 10. Then WR to 8'hFF -> cpu_en=0 and done=1 on the next cycle; mem[FF] written.
- WR=1 to 8'h20 while IDLE and while in LOAD -> mem[20] unchanged.
- Assert rst low after 6 LOAD bytes -> all outputs at reset values immediately; mem[1] unchanged. A new LOAD starts again at ptr 0.
- host_len=0 LOAD -> 1024 bytes accepted, covering words 0..255, with no extra write to word 0. Also: host_start_load and host_start_dump pulsed in the same cycle -> LOAD entered.
